// File: rtl/line_seg_queue_if.sv
// Segment queue port bundle: producer write side, rasterizer read side and
// the occupancy/status flags reported back to the producer.
interface line_seg_queue_if #(
  parameter int COORD_W = 13,
  parameter int INT_W   = 4,
  parameter int DEPTH   = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               flush;
  logic               wr_en;
  logic [COORD_W-1:0] wr_start_x;
  logic [COORD_W-1:0] wr_start_y;
  logic [COORD_W-1:0] wr_end_x;
  logic [COORD_W-1:0] wr_end_y;
  logic [INT_W-1:0]   wr_intensity;
  logic               rd_en;
  logic [COORD_W-1:0] rd_start_x;
  logic [COORD_W-1:0] rd_start_y;
  logic [COORD_W-1:0] rd_end_x;
  logic [COORD_W-1:0] rd_end_y;
  logic [INT_W-1:0]   rd_intensity;
  logic               empty;
  logic               full;
  logic               almost_full;
  logic [CNT_W-1:0]   count;
  logic [7:0]         drop_cnt;

  modport master (
    output flush, wr_en, wr_start_x, wr_start_y, wr_end_x, wr_end_y,
           wr_intensity, rd_en,
    input  rd_start_x, rd_start_y, rd_end_x, rd_end_y, rd_intensity,
           empty, full, almost_full, count, drop_cnt
  );

  modport slave (
    input  flush, wr_en, wr_start_x, wr_start_y, wr_end_x, wr_end_y,
           wr_intensity, rd_en,
    output rd_start_x, rd_start_y, rd_end_x, rd_end_y, rd_intensity,
           empty, full, almost_full, count, drop_cnt
  );
endinterface

// File: rtl/line_seg_queue.sv
// Show-ahead FIFO of complete line segments between the vector generator and
// the rasterizer, with optional blank-move filtering and drop-on-full policy.
module line_seg_queue #(
  parameter int COORD_W      = 13,
  parameter int INT_W        = 4,
  parameter int DEPTH        = 16,
  parameter int AFULL_LVL    = DEPTH - 2,
  parameter int DROP_ON_FULL = 0,
  parameter int SKIP_BLANK   = 1
) (
  input  logic            clk,
  input  logic            rst_l,
  line_seg_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic [COORD_W-1:0] ex;
    logic [COORD_W-1:0] ey;
    logic [INT_W-1:0]   inten;
  } seg_t;

  seg_t             mem_q [DEPTH];
  seg_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic is_full, is_empty, is_blank, push, pop, overflow;
  seg_t wr_seg;

  // Acceptance looks only at the registered full flag, so a same-cycle pop
  // never opens a slot for a push.
  always_comb begin
    is_full   = (count_q == CNT_W'(DEPTH));
    is_empty  = (count_q == '0);
    is_blank  = (SKIP_BLANK != 0) && (q.wr_intensity == '0);
    push      = q.wr_en && !q.flush && !is_full && !is_blank;
    pop       = q.rd_en && !q.flush && !is_empty;
    overflow  = q.wr_en && !q.flush && is_full && !is_blank && (DROP_ON_FULL != 0);
    wr_seg    = '{sx: q.wr_start_x, sy: q.wr_start_y, ex: q.wr_end_x,
                  ey: q.wr_end_y, inten: q.wr_intensity};

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_seg;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (overflow && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Flush wins over any push or pop, but keeps array contents and drop_cnt.
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign q.rd_start_x   = mem_q[rd_ptr_q].sx;
  assign q.rd_start_y   = mem_q[rd_ptr_q].sy;
  assign q.rd_end_x     = mem_q[rd_ptr_q].ex;
  assign q.rd_end_y     = mem_q[rd_ptr_q].ey;
  assign q.rd_intensity = mem_q[rd_ptr_q].inten;
  assign q.empty        = is_empty;
  assign q.full         = is_full;
  assign q.almost_full  = (count_q >= CNT_W'(AFULL_LVL));
  assign q.count        = count_q;
  assign q.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_line_seg_queue.sv
// Scoreboard bench for line_seg_queue: dut_a runs stall mode without blank
// filtering, dut_b runs drop-on-full with blank filtering.
module tb_line_seg_queue;
  localparam int COORD_W = 13;
  localparam int INT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int AFULL   = 14;

  typedef struct packed {
    logic [COORD_W-1:0] sx;
    logic [COORD_W-1:0] sy;
    logic [COORD_W-1:0] ex;
    logic [COORD_W-1:0] ey;
    logic [INT_W-1:0]   inten;
  } seg_t;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  line_seg_queue_if #(.COORD_W(COORD_W), .INT_W(INT_W), .DEPTH(DEPTH)) ifa ();
  line_seg_queue_if #(.COORD_W(COORD_W), .INT_W(INT_W), .DEPTH(DEPTH)) ifb ();

  line_seg_queue #(
    .COORD_W(COORD_W), .INT_W(INT_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL),
    .DROP_ON_FULL(0), .SKIP_BLANK(0)
  ) dut_a (.clk(clk), .rst_l(rst_l), .q(ifa.slave));

  line_seg_queue #(
    .COORD_W(COORD_W), .INT_W(INT_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL),
    .DROP_ON_FULL(1), .SKIP_BLANK(1)
  ) dut_b (.clk(clk), .rst_l(rst_l), .q(ifb.slave));

  int   errors = 0;
  int   checks = 0;
  int   m_count [2];
  int   m_drop  [2];
  bit   m_skip  [2] = '{1'b0, 1'b1};
  bit   m_dmode [2] = '{1'b0, 1'b1};
  seg_t exp_q0 [$];
  seg_t exp_q1 [$];
  seg_t seg_zero = '0;

  task automatic compare(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic seg_t mk_seg(int sx, int inten);
    seg_t s;
    s.sx    = COORD_W'(sx);
    s.sy    = COORD_W'(sx + 100);
    s.ex    = COORD_W'(sx + 200);
    s.ey    = COORD_W'(sx + 300);
    s.inten = INT_W'(inten);
    return s;
  endfunction

  // Drive one cycle of stimulus on the selected queue, record the expected
  // effect in the model, then return 1ns after the capturing edge.
  task automatic applyStimulus(int sel, bit fl, bit we, seg_t s, bit re);
    bit blank, push, pop, ovf;
    if (sel == 0) begin
      ifa.flush = fl; ifa.wr_en = we; ifa.rd_en = re;
      ifa.wr_start_x = s.sx; ifa.wr_start_y = s.sy;
      ifa.wr_end_x = s.ex; ifa.wr_end_y = s.ey; ifa.wr_intensity = s.inten;
    end else begin
      ifb.flush = fl; ifb.wr_en = we; ifb.rd_en = re;
      ifb.wr_start_x = s.sx; ifb.wr_start_y = s.sy;
      ifb.wr_end_x = s.ex; ifb.wr_end_y = s.ey; ifb.wr_intensity = s.inten;
    end
    blank = m_skip[sel] && (s.inten == '0);
    push  = we && !fl && (m_count[sel] < DEPTH) && !blank;
    pop   = re && !fl && (m_count[sel] > 0);
    ovf   = we && !fl && (m_count[sel] == DEPTH) && !blank && m_dmode[sel];
    if (fl) begin
      m_count[sel] = 0;
      if (sel == 0) exp_q0.delete(); else exp_q1.delete();
    end else begin
      if (push) begin
        if (sel == 0) exp_q0.push_back(s); else exp_q1.push_back(s);
      end
      m_count[sel] = m_count[sel] + int'(push) - int'(pop);
    end
    if (ovf && m_drop[sel] < 255) m_drop[sel]++;
    @(posedge clk);
    #1;
  endtask

  // Compare the status outputs of one queue against the model.
  task automatic checkOutput(int sel);
    if (sel == 0) begin
      compare("a_count", ifa.count, m_count[0]);
      compare("a_empty", ifa.empty, m_count[0] == 0);
      compare("a_full", ifa.full, m_count[0] == DEPTH);
      compare("a_almost_full", ifa.almost_full, m_count[0] >= AFULL);
      compare("a_drop_cnt", ifa.drop_cnt, m_drop[0]);
    end else begin
      compare("b_count", ifb.count, m_count[1]);
      compare("b_empty", ifb.empty, m_count[1] == 0);
      compare("b_full", ifb.full, m_count[1] == DEPTH);
      compare("b_almost_full", ifb.almost_full, m_count[1] >= AFULL);
      compare("b_drop_cnt", ifb.drop_cnt, m_drop[1]);
    end
  endtask

  // Monitor for dut_a: whenever a pop will be taken, the presented head must
  // match the oldest expected segment.
  always @(negedge clk) begin
    if (rst_l && ifa.rd_en && !ifa.flush && !ifa.empty) begin
      if (exp_q0.size() == 0) begin
        compare("a_pop_unexpected", 1, 0);
      end else begin
        seg_t e;
        e = exp_q0.pop_front();
        compare("a_pop_seg", {ifa.rd_start_x, ifa.rd_start_y, ifa.rd_end_x,
                              ifa.rd_end_y, ifa.rd_intensity}, e);
      end
    end
  end

  // Same monitor for dut_b.
  always @(negedge clk) begin
    if (rst_l && ifb.rd_en && !ifb.flush && !ifb.empty) begin
      if (exp_q1.size() == 0) begin
        compare("b_pop_unexpected", 1, 0);
      end else begin
        seg_t e;
        e = exp_q1.pop_front();
        compare("b_pop_seg", {ifb.rd_start_x, ifb.rd_start_y, ifb.rd_end_x,
                              ifb.rd_end_y, ifb.rd_intensity}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ifa.flush = 0; ifa.wr_en = 0; ifa.rd_en = 0;
    ifa.wr_start_x = '0; ifa.wr_start_y = '0; ifa.wr_end_x = '0;
    ifa.wr_end_y = '0; ifa.wr_intensity = '0;
    ifb.flush = 0; ifb.wr_en = 0; ifb.rd_en = 0;
    ifb.wr_start_x = '0; ifb.wr_start_y = '0; ifb.wr_end_x = '0;
    ifb.wr_end_y = '0; ifb.wr_intensity = '0;
    m_count = '{0, 0};
    m_drop  = '{0, 0};
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_l = 1'b1;

    $display("[TB] reset state");
    checkOutput(0);
    checkOutput(1);
    compare("a_reset_rd_seg", {ifa.rd_start_x, ifa.rd_start_y, ifa.rd_end_x,
                               ifa.rd_end_y, ifa.rd_intensity}, 0);

    $display("[TB] fill dut_a to 16");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1, mk_seg(i, i), 0);
      checkOutput(0);
    end

    $display("[TB] stall while full");
    repeat (3) begin
      applyStimulus(0, 0, 1, mk_seg(999, 3), 0);
      checkOutput(0);
    end
    compare("a_stall_head", ifa.rd_start_x, 0);
    applyStimulus(0, 0, 1, mk_seg(999, 3), 1);
    checkOutput(0);
    applyStimulus(0, 0, 1, mk_seg(999, 3), 0);
    checkOutput(0);

    $display("[TB] drain dut_a");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, seg_zero, 1);
      checkOutput(0);
    end
    compare("a_drain_left", exp_q0.size(), 0);

    $display("[TB] concurrent push/pop across wrap");
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, mk_seg(20 + i, 1), 0);
    checkOutput(0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 1, mk_seg(28 + i, 2), 1);
      checkOutput(0);
    end

    $display("[TB] flush with write");
    applyStimulus(0, 1, 1, mk_seg(4000, 6), 0);
    checkOutput(0);
    applyStimulus(0, 0, 0, seg_zero, 0);
    checkOutput(0);

    $display("[TB] asynchronous reset mid-burst");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, mk_seg(300 + i, 4), 0);
    checkOutput(0);
    #2 rst_l = 1'b0;
    #1;
    m_count[0] = 0;
    exp_q0.delete();
    checkOutput(0);
    compare("a_rst_rd_start_x", ifa.rd_start_x, 0);
    #3 rst_l = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, mk_seg(77 + i, 8), 0);
    checkOutput(0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, seg_zero, 1);
    checkOutput(0);
    compare("a_post_reset_left", exp_q0.size(), 0);

    $display("[TB] blank skip on dut_b");
    applyStimulus(1, 0, 1, mk_seg(1, 5), 0);
    applyStimulus(1, 0, 1, mk_seg(2, 0), 0);
    applyStimulus(1, 0, 1, mk_seg(3, 7), 0);
    checkOutput(1);
    applyStimulus(1, 0, 0, seg_zero, 1);
    applyStimulus(1, 0, 0, seg_zero, 1);
    checkOutput(1);

    $display("[TB] drop-on-full saturation on dut_b");
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, mk_seg(600 + i, (i % 15) + 1), 0);
    checkOutput(1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 0, 1, mk_seg(500, 9), 0);
      checkOutput(1);
    end
    compare("b_head_kept", ifb.rd_start_x, exp_q1[0].sx);
    applyStimulus(1, 0, 1, mk_seg(501, 0), 0);
    checkOutput(1);
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, seg_zero, 1);
    checkOutput(1);
    compare("b_drain_left", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
